// File: rtl/wb_regfile.sv
// wb_regfile: write-back stage and architectural integer register file.
//
// Selects write-back data from the MEM/WB register outputs (load data or ALU
// result), commits it to the register file and serves the decode stage's two
// combinational read ports. A read of the register being committed in the
// same cycle sees the new value through a write-through bypass. A free-running
// counter tracks committed register writes.
//
// Ports:
//   clk, rst          - clock; synchronous active-high reset
//   m_data_out        - load data from MEM/WB
//   ex_result_out     - ALU/address result from MEM/WB
//   wb_reg_write_out  - register write enable from MEM/WB
//   wb_memtoreg_out   - 1 selects m_data_out, 0 selects ex_result_out
//   rd_index_out      - destination register index
//   rs1_index/rs2_index - read port indices from ID
//   rs1_data/rs2_data   - read port data (x0 reads zero)
//   wb_data           - selected write-back value, forwarded to EX
//   wb_valid          - write-back is architecturally effective this cycle
//   wr_count          - committed register writes since reset (wraps)
module wb_regfile #(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned RFIDX_WIDTH = 5,
  parameter int unsigned NREGS       = 32,
  parameter int unsigned CNT_WIDTH   = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [XLEN-1:0]        m_data_out,
  input  logic [XLEN-1:0]        ex_result_out,
  input  logic                   wb_reg_write_out,
  input  logic                   wb_memtoreg_out,
  input  logic [RFIDX_WIDTH-1:0] rd_index_out,
  input  logic [RFIDX_WIDTH-1:0] rs1_index,
  input  logic [RFIDX_WIDTH-1:0] rs2_index,
  output logic [XLEN-1:0]        rs1_data,
  output logic [XLEN-1:0]        rs2_data,
  output logic [XLEN-1:0]        wb_data,
  output logic                   wb_valid,
  output logic [CNT_WIDTH-1:0]   wr_count
);

  // x0 is hardwired to zero, so only entries 1..NREGS-1 are stored.
  logic [XLEN-1:0]      regs [1:NREGS-1];
  logic [CNT_WIDTH-1:0] wr_count_q;

  always_comb begin
    wb_data  = wb_memtoreg_out ? m_data_out : ex_result_out;
    wb_valid = wb_reg_write_out && (rd_index_out != '0);
  end

  // Read ports: x0 first, then same-cycle bypass, then stored value.
  always_comb begin
    rs1_data = '0;
    if (rs1_index != '0) begin
      if (wb_valid && (rs1_index == rd_index_out))
        rs1_data = wb_data;
      else
        rs1_data = regs[rs1_index];
    end
  end

  always_comb begin
    rs2_data = '0;
    if (rs2_index != '0) begin
      if (wb_valid && (rs2_index == rd_index_out))
        rs2_data = wb_data;
      else
        rs2_data = regs[rs2_index];
    end
  end

  // Reset takes priority and discards any write presented in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      regs       <= '{default: '0};
      wr_count_q <= '0;
    end else if (wb_valid) begin
      regs[rd_index_out] <= wb_data;
      wr_count_q         <= wr_count_q + CNT_WIDTH'(1);
    end
  end

  assign wr_count = wr_count_q;

endmodule

// File: tb/tb_wb_regfile.sv
module tb_wb_regfile;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] m_data_out;
  logic [31:0] ex_result_out;
  logic        wb_reg_write_out;
  logic        wb_memtoreg_out;
  logic [4:0]  rd_index_out;
  logic [4:0]  rs1_index;
  logic [4:0]  rs2_index;
  logic [31:0] rs1_data, rs2_data, wb_data;
  logic        wb_valid;
  logic [31:0] wr_count;

  logic [31:0] rs1_data_w4, rs2_data_w4, wb_data_w4;
  logic        wb_valid_w4;
  logic [3:0]  wr_count_w4;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  // Reference model state
  logic [31:0] mregs [32];
  logic [31:0] mcnt;

  // Scoreboard of expected values, pushed when stimulus is applied
  logic [31:0] exp_q [$];

  always #5 clk = ~clk;

  wb_regfile u_dut (
    .clk(clk), .rst(rst),
    .m_data_out(m_data_out), .ex_result_out(ex_result_out),
    .wb_reg_write_out(wb_reg_write_out), .wb_memtoreg_out(wb_memtoreg_out),
    .rd_index_out(rd_index_out), .rs1_index(rs1_index), .rs2_index(rs2_index),
    .rs1_data(rs1_data), .rs2_data(rs2_data),
    .wb_data(wb_data), .wb_valid(wb_valid), .wr_count(wr_count)
  );

  wb_regfile #(.CNT_WIDTH(4)) u_dut_w4 (
    .clk(clk), .rst(rst),
    .m_data_out(m_data_out), .ex_result_out(ex_result_out),
    .wb_reg_write_out(wb_reg_write_out), .wb_memtoreg_out(wb_memtoreg_out),
    .rd_index_out(rd_index_out), .rs1_index(rs1_index), .rs2_index(rs2_index),
    .rs1_data(rs1_data_w4), .rs2_data(rs2_data_w4),
    .wb_data(wb_data_w4), .wb_valid(wb_valid_w4), .wr_count(wr_count_w4)
  );

  // Advance one clock edge, updating the model from the inputs held across it.
  task automatic cycle();
    logic [31:0] sel;
    @(posedge clk);
    sel = wb_memtoreg_out ? m_data_out : ex_result_out;
    if (rst) begin
      for (int i = 0; i < 32; i++) mregs[i] = '0;
      mcnt = '0;
    end else if (wb_reg_write_out && rd_index_out != 5'd0) begin
      mregs[rd_index_out] = sel;
      mcnt = mcnt + 32'd1;
    end
    #1;
  endtask

  task automatic idle_inputs();
    wb_reg_write_out = 1'b0;
    wb_memtoreg_out  = 1'b0;
    rd_index_out     = '0;
    m_data_out       = '0;
    ex_result_out    = '0;
  endtask

  task automatic test_reset();
    logic [31:0] e, got;
    rst = 1'b1;
    idle_inputs();
    rs1_index = '0;
    rs2_index = '0;
    cycle();
    cycle();
    rst = 1'b0;
    #1;
    for (int i = 0; i < 32; i++) begin
      rs1_index = 5'(i);
      rs2_index = 5'(31 - i);
      #1;
      exp_q.push_back(32'd0);
      exp_q.push_back(32'd0);
      e = exp_q.pop_front(); got = rs1_data; n_checks++;
      if (got !== e) begin
        $display("FAIL reset_rs1[%0d]: got %h expected %h", i, got, e); n_fail++;
      end
      e = exp_q.pop_front(); got = rs2_data; n_checks++;
      if (got !== e) begin
        $display("FAIL reset_rs2[%0d]: got %h expected %h", 31 - i, got, e); n_fail++;
      end
    end
    exp_q.push_back(32'd0);
    e = exp_q.pop_front(); n_checks++;
    if (wr_count !== e) begin
      $display("FAIL reset_count: got %h expected %h", wr_count, e); n_fail++;
    end
    n_checks++;
    if (wr_count_w4 !== 4'd0) begin
      $display("FAIL reset_count_w4: got %h expected 0", wr_count_w4); n_fail++;
    end
  endtask

  task automatic test_write_select();
    logic [31:0] e;
    for (int k = 0; k < 2; k++) begin
      wb_reg_write_out = 1'b1;
      wb_memtoreg_out  = (k == 1);
      rd_index_out     = 5'd5;
      ex_result_out    = 32'h12345678;
      m_data_out       = 32'hDEADBEEF;
      rs1_index        = 5'd1;
      #1;
      exp_q.push_back(k == 1 ? 32'hDEADBEEF : 32'h12345678);
      e = exp_q.pop_front(); n_checks++;
      if (wb_data !== e) begin
        $display("FAIL wb_data_sel%0d: got %h expected %h", k, wb_data, e); n_fail++;
      end
      n_checks++;
      if (wb_valid !== 1'b1) begin
        $display("FAIL wb_valid_sel%0d: got %b expected 1", k, wb_valid); n_fail++;
      end
      cycle();
      idle_inputs();
      rs1_index = 5'd5;
      #1;
      exp_q.push_back(k == 1 ? 32'hDEADBEEF : 32'h12345678);
      exp_q.push_back(32'(k + 1));
      e = exp_q.pop_front(); n_checks++;
      if (rs1_data !== e) begin
        $display("FAIL read_x5_sel%0d: got %h expected %h", k, rs1_data, e); n_fail++;
      end
      e = exp_q.pop_front(); n_checks++;
      if (wr_count !== e) begin
        $display("FAIL count_sel%0d: got %h expected %h", k, wr_count, e); n_fail++;
      end
    end
  endtask

  task automatic test_x0_write();
    logic [31:0] e;
    wb_reg_write_out = 1'b1;
    wb_memtoreg_out  = 1'b0;
    rd_index_out     = 5'd0;
    ex_result_out    = 32'hFFFFFFFF;
    rs1_index        = 5'd0;
    #1;
    n_checks++;
    if (wb_valid !== 1'b0) begin
      $display("FAIL x0_wb_valid: got %b expected 0", wb_valid); n_fail++;
    end
    exp_q.push_back(32'd0);
    e = exp_q.pop_front(); n_checks++;
    if (rs1_data !== e) begin
      $display("FAIL x0_bypass: got %h expected %h", rs1_data, e); n_fail++;
    end
    cycle();
    idle_inputs();
    #1;
    exp_q.push_back(32'd0);
    exp_q.push_back(32'd2);
    e = exp_q.pop_front(); n_checks++;
    if (rs1_data !== e) begin
      $display("FAIL x0_read: got %h expected %h", rs1_data, e); n_fail++;
    end
    e = exp_q.pop_front(); n_checks++;
    if (wr_count !== e) begin
      $display("FAIL x0_count: got %h expected %h", wr_count, e); n_fail++;
    end
  endtask

  task automatic test_bypass();
    logic [31:0] e;
    wb_reg_write_out = 1'b1;
    wb_memtoreg_out  = 1'b0;
    rd_index_out     = 5'd7;
    ex_result_out    = 32'hA5A5A5A5;
    rs1_index        = 5'd7;
    rs2_index        = 5'd7;
    #1;
    for (int ph = 0; ph < 2; ph++) begin
      exp_q.push_back(32'hA5A5A5A5);
      exp_q.push_back(32'hA5A5A5A5);
      e = exp_q.pop_front(); n_checks++;
      if (rs1_data !== e) begin
        $display("FAIL bypass_rs1_ph%0d: got %h expected %h", ph, rs1_data, e); n_fail++;
      end
      e = exp_q.pop_front(); n_checks++;
      if (rs2_data !== e) begin
        $display("FAIL bypass_rs2_ph%0d: got %h expected %h", ph, rs2_data, e); n_fail++;
      end
      if (ph == 0) begin
        cycle();
        idle_inputs();
        #1;
      end
    end
  endtask

  task automatic test_reset_discard();
    logic [31:0] e;
    rst = 1'b1;
    wb_reg_write_out = 1'b1;
    rd_index_out     = 5'd9;
    ex_result_out    = 32'h11;
    cycle();
    rst = 1'b0;
    idle_inputs();
    rs1_index = 5'd9;
    rs2_index = 5'd5;
    #1;
    exp_q.push_back(32'd0);
    exp_q.push_back(32'd0);
    exp_q.push_back(32'd0);
    e = exp_q.pop_front(); n_checks++;
    if (rs1_data !== e) begin
      $display("FAIL rstwr_x9: got %h expected %h", rs1_data, e); n_fail++;
    end
    e = exp_q.pop_front(); n_checks++;
    if (rs2_data !== e) begin
      $display("FAIL rstwr_x5: got %h expected %h", rs2_data, e); n_fail++;
    end
    e = exp_q.pop_front(); n_checks++;
    if (wr_count !== e) begin
      $display("FAIL rstwr_count: got %h expected %h", wr_count, e); n_fail++;
    end
    wb_reg_write_out = 1'b1;
    rd_index_out     = 5'd9;
    ex_result_out    = 32'h22;
    cycle();
    idle_inputs();
    #1;
    exp_q.push_back(32'h22);
    exp_q.push_back(32'd1);
    e = exp_q.pop_front(); n_checks++;
    if (rs1_data !== e) begin
      $display("FAIL postrst_x9: got %h expected %h", rs1_data, e); n_fail++;
    end
    e = exp_q.pop_front(); n_checks++;
    if (wr_count !== e) begin
      $display("FAIL postrst_count: got %h expected %h", wr_count, e); n_fail++;
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] e;
    for (int k = 1; k <= 3; k++) begin
      wb_reg_write_out = 1'b1;
      wb_memtoreg_out  = 1'b1;
      rd_index_out     = 5'd3;
      m_data_out       = 32'(k * 32'h1000 + k);
      cycle();
    end
    idle_inputs();
    rs1_index = 5'd3;
    rs2_index = 5'd9;
    #1;
    exp_q.push_back(32'h3003);
    exp_q.push_back(32'h22);
    exp_q.push_back(32'd4);
    e = exp_q.pop_front(); n_checks++;
    if (rs1_data !== e) begin
      $display("FAIL b2b_x3: got %h expected %h", rs1_data, e); n_fail++;
    end
    e = exp_q.pop_front(); n_checks++;
    if (rs2_data !== e) begin
      $display("FAIL b2b_x9: got %h expected %h", rs2_data, e); n_fail++;
    end
    e = exp_q.pop_front(); n_checks++;
    if (wr_count !== e) begin
      $display("FAIL b2b_count: got %h expected %h", wr_count, e); n_fail++;
    end
  endtask

  task automatic test_wrap();
    logic [31:0] e;
    rst = 1'b1;
    idle_inputs();
    cycle();
    rst = 1'b0;
    for (int k = 0; k < 17; k++) begin
      wb_reg_write_out = 1'b1;
      wb_memtoreg_out  = k[0];
      rd_index_out     = 5'((k % 31) + 1);
      m_data_out       = $urandom;
      ex_result_out    = $urandom;
      cycle();
    end
    idle_inputs();
    #1;
    exp_q.push_back(32'd1);
    exp_q.push_back(32'd17);
    e = exp_q.pop_front(); n_checks++;
    if ({28'd0, wr_count_w4} !== e) begin
      $display("FAIL wrap_count_w4: got %h expected %h", wr_count_w4, e); n_fail++;
    end
    e = exp_q.pop_front(); n_checks++;
    if (wr_count !== e) begin
      $display("FAIL wrap_count_w32: got %h expected %h", wr_count, e); n_fail++;
    end
  endtask

  task automatic test_random();
    logic [31:0] e, sel;
    for (int k = 0; k < 300; k++) begin
      wb_reg_write_out = ($urandom_range(0, 3) != 0);
      wb_memtoreg_out  = $urandom_range(0, 1);
      rd_index_out     = 5'($urandom_range(0, 31));
      m_data_out       = $urandom;
      ex_result_out    = $urandom;
      rs1_index        = ($urandom_range(0, 3) == 0) ? rd_index_out : 5'($urandom_range(0, 31));
      rs2_index        = 5'($urandom_range(0, 31));
      #1;
      sel = wb_memtoreg_out ? m_data_out : ex_result_out;
      if (rs1_index == 5'd0) exp_q.push_back(32'd0);
      else if (wb_reg_write_out && rd_index_out != 5'd0 && rs1_index == rd_index_out) exp_q.push_back(sel);
      else exp_q.push_back(mregs[rs1_index]);
      if (rs2_index == 5'd0) exp_q.push_back(32'd0);
      else if (wb_reg_write_out && rd_index_out != 5'd0 && rs2_index == rd_index_out) exp_q.push_back(sel);
      else exp_q.push_back(mregs[rs2_index]);
      exp_q.push_back(mcnt);
      e = exp_q.pop_front(); n_checks++;
      if (rs1_data !== e) begin
        $display("FAIL rand_rs1[%0d] idx %0d: got %h expected %h", k, rs1_index, rs1_data, e); n_fail++;
      end
      e = exp_q.pop_front(); n_checks++;
      if (rs2_data !== e) begin
        $display("FAIL rand_rs2[%0d] idx %0d: got %h expected %h", k, rs2_index, rs2_data, e); n_fail++;
      end
      e = exp_q.pop_front(); n_checks++;
      if (wr_count !== e) begin
        $display("FAIL rand_count[%0d]: got %h expected %h", k, wr_count, e); n_fail++;
      end
      n_checks++;
      if (wr_count_w4 !== mcnt[3:0]) begin
        $display("FAIL rand_count_w4[%0d]: got %h expected %h", k, wr_count_w4, mcnt[3:0]); n_fail++;
      end
      cycle();
    end
    idle_inputs();
  endtask

  initial begin
    for (int i = 0; i < 32; i++) mregs[i] = '0;
    mcnt = '0;
    test_reset();
    test_write_select();
    test_x0_write();
    test_bypass();
    test_reset_discard();
    test_back_to_back();
    test_wrap();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
